dt_walk_engine: RTL and testbench

//  Runtime-programmable decision-tree classifier: walks a node table one node per clock.

---
 rtl/dt_pkg.sv | 51 +++++
 rtl/dt_node_table.sv | 40 ++++
 rtl/dt_walk_engine.sv | 175 +++++++++++++++++
 tb/tb_dt_walk_engine.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dt_pkg.sv
// ---------------------------------------------------------------------------
// dt_pkg
// Shared types and constants for the decision-tree walk engine.
//   node_t      : one node table entry {leaf, feat, thr, left, right, cls}
//   calc_node_w : packed node width from N, F, C and AW
//   state_t     : walk FSM states
//   STAT_W      : per-class statistics counter width
// ---------------------------------------------------------------------------
package dt_pkg;

    localparam int N         = 8;               // feature / threshold width
    localparam int F         = 4;               // features per sample
    localparam int C         = 2;               // class code width
    localparam int NODES     = 16;              // node table depth
    localparam int AW        = $clog2(NODES);   // node index width
    localparam int MAX_DEPTH = 8;               // walk steps before error
    localparam int FW        = $clog2(F);       // feature select width
    localparam int DW        = $clog2(MAX_DEPTH);
    localparam int STAT_W    = 16;

    function automatic int calc_node_w(input int n, input int f, input int c, input int aw);
        return 1 + $clog2(f) + n + 2 * aw + c;
    endfunction

    localparam int NODE_W = calc_node_w(N, F, C, AW);

    typedef struct packed {
        logic          leaf;
        logic [FW-1:0] feat;
        logic [N-1:0]  thr;
        logic [AW-1:0] left;
        logic [AW-1:0] right;
        logic [C-1:0]  cls;
    } node_t;

    typedef enum logic [1:0] {
        IDLE,
        WALK,
        DONE
    } state_t;

    // A table entry after reset: a class-0 leaf, so an unprogrammed tree
    // classifies everything as class 0 in one step.
    function automatic node_t reset_node();
        node_t n;
        n      = '0;
        n.leaf = 1'b1;
        return n;
    endfunction

endpackage

// File: rtl/dt_node_table.sv
// ---------------------------------------------------------------------------
// dt_node_table
// NODES x node_t register file: one synchronous write port, one
// combinational read port. Every entry resets to a class-0 leaf.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_we              write strobe (already qualified by the caller)
//   i_waddr, i_wdata  write index and node
//   i_raddr           read index
//   o_rdata           node at i_raddr (combinational)
// ---------------------------------------------------------------------------
module dt_node_table
    import dt_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  node_t         i_wdata,
    input  logic [AW-1:0] i_raddr,
    output node_t         o_rdata
);

    node_t r_mem [NODES];

    // NOTE: this table is built from flops, not RAM, precisely so it can be
    // reset; a reset on a real memory array would block RAM inference.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NODES; i++) begin
                r_mem[i] <= reset_node();
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dt_walk_engine.sv
// ---------------------------------------------------------------------------
// dt_walk_engine
// Runtime-programmable decision-tree classifier. A sample is accepted in
// IDLE, the tree is walked one node per clock in WALK, and the class is
// held in DONE until the sink takes it.
// Optional feature: define DT_STATS_EN for per-class result counters.
// Ports:
//   clk, rst_n                clock, asynchronous active-low reset
//   stat_sel/clr/count        (DT_STATS_EN only) counter select, clear, value
//   in_valid/in_ready         sample handshake
//   in_features               feature f at [f*N +: N]
//   out_valid/out_ready       result handshake
//   out_cls, out_err          class code, walk aborted flag
//   cfg_we/addr/wdata         node table write port (IDLE only)
//   busy                      engine not idle
// ---------------------------------------------------------------------------
module dt_walk_engine
    import dt_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
`ifdef DT_STATS_EN
    input  logic [C-1:0]      stat_sel,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] stat_count,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [F*N-1:0]    in_features,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [C-1:0]      out_cls,
    output logic              out_err,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [NODE_W-1:0] cfg_wdata,
    output logic              busy
);

    state_t         r_state;
    state_t         w_next_state;
    logic [N-1:0]   r_features [F];
    logic [AW-1:0]  r_ptr;
    logic [DW-1:0]  r_depth;
    logic [C-1:0]   r_cls;
    logic           r_err;

    node_t          w_node;
    logic [N-1:0]   w_feat_val;
    logic [AW-1:0]  w_next_idx;
    logic           w_fault;
    logic           w_accept;
    logic           w_cfg_wr;

    // Writes outside IDLE are dropped so the table is frozen during a walk.
    assign w_cfg_wr = cfg_we && (r_state == IDLE);
    assign w_accept = in_valid && in_ready;

    dt_node_table u_table (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_cfg_wr),
        .i_waddr (cfg_addr),
        .i_wdata (node_t'(cfg_wdata)),
        .i_raddr (r_ptr),
        .o_rdata (w_node)
    );

    assign w_feat_val = r_features[w_node.feat];
    assign w_next_idx = (w_feat_val < w_node.thr) ? w_node.left : w_node.right;
    // The index range test is always false while NODES is a power of two;
    // it stays so a non-power-of-two table still traps dangling links.
    assign w_fault    = (32'(w_next_idx) >= NODES) ||
                        (r_depth == DW'(MAX_DEPTH - 1));

    // ---------------- FSM: state register ----------------
    // NOTE: clocked state uses non-blocking assignment so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next state ----------------
    // NOTE: the default assignment first keeps every path assigned, so no
    // latch is inferred when a branch does not mention w_next_state.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = WALK;
            WALK:    if (w_node.leaf || w_fault) w_next_state = DONE;
            DONE:    if (out_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // A pending config write claims the IDLE cycle, hence in_ready drops.
    always_comb begin
        in_ready  = (r_state == IDLE) && !cfg_we;
        out_valid = (r_state == DONE);
        busy      = (r_state != IDLE);
    end

    // ---------------- Walk datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int f = 0; f < F; f++) begin
                r_features[f] <= '0;
            end
            r_ptr   <= '0;
            r_depth <= '0;
            r_cls   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        for (int f = 0; f < F; f++) begin
                            r_features[f] <= in_features[f*N +: N];
                        end
                        r_ptr   <= '0;
                        r_depth <= '0;
                    end
                end
                WALK: begin
                    // A leaf wins over the depth limit: the last allowed
                    // step may still land on a valid result.
                    if (w_node.leaf) begin
                        r_cls <= w_node.cls;
                        r_err <= 1'b0;
                    end else if (w_fault) begin
                        r_cls <= '0;
                        r_err <= 1'b1;
                    end else begin
                        r_ptr   <= w_next_idx;
                        r_depth <= r_depth + DW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_cls = r_cls;
    assign out_err = r_err;

`ifdef DT_STATS_EN
    // ---------------- Per-class result counters ----------------
    logic [STAT_W-1:0] r_stat_cnt [2**C];
    logic              w_stat_inc;

    assign w_stat_inc = out_valid && out_ready && !r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2**C; k++) begin
                r_stat_cnt[k] <= '0;
            end
        end else if (stat_clr) begin
            for (int k = 0; k < 2**C; k++) begin
                r_stat_cnt[k] <= '0;
            end
        end else if (w_stat_inc && (r_stat_cnt[r_cls] != '1)) begin
            r_stat_cnt[r_cls] <= r_stat_cnt[r_cls] + STAT_W'(1);
        end
    end

    assign stat_count = r_stat_cnt[stat_sel];
`endif

endmodule

// File: tb/tb_dt_walk_engine.sv
// ---------------------------------------------------------------------------
// tb_dt_walk_engine
// Self-checking bench for dt_walk_engine: directed scenarios plus random
// trees and features compared against a behavioural tree-walk model.
// ---------------------------------------------------------------------------
module tb_dt_walk_engine;
    import dt_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [F*N-1:0]    in_features;
    logic              out_valid;
    logic              out_ready;
    logic [C-1:0]      out_cls;
    logic              out_err;
    logic              cfg_we;
    logic [AW-1:0]     cfg_addr;
    logic [NODE_W-1:0] cfg_wdata;
    logic              busy;
`ifdef DT_STATS_EN
    logic [C-1:0]      stat_sel;
    logic              stat_clr;
    logic [STAT_W-1:0] stat_count;
`endif

    dt_walk_engine dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef DT_STATS_EN
        .stat_sel    (stat_sel),
        .stat_clr    (stat_clr),
        .stat_count  (stat_count),
`endif
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_features (in_features),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_cls     (out_cls),
        .out_err     (out_err),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int    n_total = 0;
    int    n_bad   = 0;
    node_t m_tbl [NODES];
    int    m_cnt [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic node_t mk_int(input int feat, input int thr, input int l, input int r);
        node_t x;
        x       = '0;
        x.feat  = FW'(feat);
        x.thr   = N'(thr);
        x.left  = AW'(l);
        x.right = AW'(r);
        return x;
    endfunction

    function automatic node_t mk_leaf(input int cls);
        node_t x;
        x      = '0;
        x.leaf = 1'b1;
        x.cls  = C'(cls);
        return x;
    endfunction

    function automatic logic [F*N-1:0] mkf(input int f0, input int f1, input int f2, input int f3);
        return {N'(f3), N'(f2), N'(f1), N'(f0)};
    endfunction

    function automatic node_t rand_node();
        node_t x;
        x       = node_t'($urandom);
        x.leaf  = ($urandom_range(0, 2) == 0);
        return x;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NODES; i++) m_tbl[i] = mk_leaf(0);
        for (int k = 0; k < 4; k++) m_cnt[k] = 0;
    endtask

    // Reference walk: follow links from the root, one step per node visited.
    function automatic void model_walk(input logic [F*N-1:0] feats, output int cls,
                                       output int err, output int lat);
        int    ptr;
        int    nxt;
        int    fv;
        node_t e;
        ptr = 0;
        cls = 0;
        err = 1;
        lat = MAX_DEPTH;
        for (int d = 0; d < MAX_DEPTH; d++) begin
            e = m_tbl[ptr];
            if (e.leaf) begin
                cls = int'(e.cls);
                err = 0;
                lat = d + 1;
                return;
            end
            fv  = int'(feats[int'(e.feat) * N +: N]);
            nxt = (fv < int'(e.thr)) ? int'(e.left) : int'(e.right);
            if (nxt >= NODES || d == MAX_DEPTH - 1) begin
                cls = 0;
                err = 1;
                lat = d + 1;
                return;
            end
            ptr = nxt;
        end
    endfunction

    task automatic note_handshake(input int cls, input int err);
        if (err == 0 && m_cnt[cls] < 65535) m_cnt[cls]++;
    endtask

    // All tasks start and end at posedge+1.
    task automatic cfg_write(input int addr, input node_t n);
        cfg_we    = 1'b1;
        cfg_addr  = AW'(addr);
        cfg_wdata = n;
        #1;
        check("cfg_blocks_in_ready", in_ready, 0);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        m_tbl[addr] = n;
    endtask

    task automatic run_sample(input string tag, input logic [F*N-1:0] feats, input int exp_cls,
                              input int exp_err, input int exp_lat, input int hold);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_ready"}, in_ready, 1);
        in_valid    = 1'b1;
        in_features = feats;
        @(posedge clk); #1;
        in_valid    = 1'b0;
        in_features = $urandom;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"}, n, exp_lat);
        check({tag, "_cls"}, out_cls, exp_cls);
        check({tag, "_err"}, out_err, exp_err);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_cls"}, out_cls, exp_cls);
            check({tag, "_hold_err"}, out_err, exp_err);
            check({tag, "_hold_in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        note_handshake(exp_cls, exp_err);
        check({tag, "_released"}, out_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ec, ee, el;
        logic [F*N-1:0] fv;

        rst_n = 1'b0; in_valid = 1'b0; in_features = '0; out_ready = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
`ifdef DT_STATS_EN
        stat_sel = '0; stat_clr = 1'b0;
`endif
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // 1. Reset state and the default one-leaf tree.
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_cls", out_cls, 0);
        check("rst_out_err", out_err, 0);
        check("rst_busy", busy, 0);
        run_sample("t1", $urandom, 0, 0, 1, 0);

        // 2. Two-level tree on feature 2 with threshold 83; cfg_we beats in_valid.
        in_valid = 1'b1;
        cfg_write(0, mk_int(2, 83, 1, 2));
        in_valid = 1'b0;
        check("cfg_priority_busy", busy, 0);
        cfg_write(1, mk_leaf(0));
        cfg_write(2, mk_leaf(1));
        run_sample("t2_pl50", mkf(200, 7, 50, 9), 0, 0, 2, 0);
        run_sample("t2_pl83", mkf(0, 0, 83, 0), 1, 0, 2, 0);
        run_sample("t2_pl82", mkf(255, 255, 82, 255), 0, 0, 2, 0);

        // 4. Sink back-pressure for 5 cycles.
        run_sample("t4_hold", mkf(1, 2, 200, 3), 1, 0, 2, 5);

        // 5. A write during the walk to the leaf being reached is dropped.
        in_features = mkf(0, 0, 90, 0);
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        check("t5_busy", busy, 1);
        cfg_we    = 1'b1;
        cfg_addr  = AW'(2);
        cfg_wdata = mk_leaf(2);
        #1;
        check("t5_in_ready_walk", in_ready, 0);
        @(posedge clk); #1;
        check("t5_not_done", out_valid, 0);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        check("t5_valid", out_valid, 1);
        check("t5_cls_old", out_cls, 1);
        check("t5_err", out_err, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        note_handshake(1, 0);
        run_sample("t5_readback", mkf(0, 0, 90, 0), 1, 0, 2, 0);

        // 3. Eight-node internal chain exceeds the depth limit.
        for (int i = 0; i < 8; i++) cfg_write(i, mk_int(0, 0, i + 1, i + 1));
        run_sample("t3_depth", $urandom, 0, 1, 8, 0);

        // Random trees against the model.
        for (int t = 0; t < 3; t++) begin
            for (int a = 0; a < NODES; a++) cfg_write(a, rand_node());
            for (int s = 0; s < 12; s++) begin
                fv = $urandom;
                model_walk(fv, ec, ee, el);
                run_sample("rnd", fv, ec, ee, el, $urandom_range(0, 2));
            end
        end

`ifdef DT_STATS_EN
        // 6a. Statistics: clear, three class-1 results, clear again.
        stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
        for (int k = 0; k < 4; k++) m_cnt[k] = 0;
        cfg_write(0, mk_int(2, 83, 1, 2));
        cfg_write(1, mk_leaf(0));
        cfg_write(2, mk_leaf(1));
        for (int s = 0; s < 3; s++) run_sample("t6_cls1", mkf(0, 0, 100 + s, 0), 1, 0, 2, 0);
        run_sample("t6_cls0", mkf(0, 0, 10, 0), 0, 0, 2, 0);
        stat_sel = 2'd1; #1;
        check("t6_stat1", stat_count, m_cnt[1]);
        check("t6_stat1_const", stat_count, 3);
        stat_sel = 2'd0; #1;
        check("t6_stat0", stat_count, m_cnt[0]);
        stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
        stat_sel = 2'd1; #1;
        check("t6_stat_clr", stat_count, 0);
`endif

        // 6b. Reset in the middle of a long walk.
        for (int i = 0; i < 8; i++) cfg_write(i, mk_int(0, 0, i + 1, i + 1));
        in_features = $urandom;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("t6_midwalk_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_in_ready", in_ready, 1);
        @(posedge clk); @(posedge clk); #1;
        check("t6_rst_hold_valid", out_valid, 0);
        rst_n = 1'b1;
        model_reset();
        fv = $urandom;
        model_walk(fv, ec, ee, el);
        run_sample("t6_after_rst", fv, 0, 0, 1, 0);
        check("t6_model_agrees", el, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
